// File: rtl/shift_right_serial.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_serial
// Function : Multi-cycle SRL/SRA unit resolving one binary shift stage per
//            clock (largest first), valid/ready handshake on both sides.
//            Optional macro SHIFT_RIGHT_ZERO_BYPASS_EN: shift_amt=0 skips
//            the SHIFT pass and completes in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module shift_right_serial #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  data_out
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [DATA_W-1:0]  r_work;
    logic [SHAMT_W-1:0] r_amt;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_fill;
    logic [DATA_W-1:0]  r_data_out;
    logic [DATA_W-1:0]  w_work_next;
    logic               w_accept;
    logic [DATA_W-1:0]  w_stage_res [SHAMT_W];

    assign w_accept = (r_state == c_IDLE) && in_valid;

    // Each stage k is a fixed shift by 2^k with the captured fill bit.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int STEP = 1 << k;
        assign w_stage_res[k] = {{STEP{r_fill}}, r_work[DATA_W-1:STEP]};
    end

    always_comb begin
        w_work_next = r_work;
        for (int k = 0; k < SHAMT_W; k++) begin
            if ((r_cnt == SHAMT_W'(k)) && r_amt[k]) begin
                w_work_next = w_stage_res[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_RIGHT_ZERO_BYPASS_EN
                    w_state_next = (shift_amt == '0) ? c_DONE : c_SHIFT;
`else
                    w_state_next = c_SHIFT;
`endif
                end
            end
            c_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_amt      <= '0;
            r_cnt      <= '0;
            r_fill     <= 1'b0;
            r_data_out <= '0;
        end else if (w_accept) begin
            r_work <= data_in;
            r_amt  <= shift_amt;
            r_fill <= arith & data_in[DATA_W-1];
            r_cnt  <= SHAMT_W'(SHAMT_W - 1);
`ifdef SHIFT_RIGHT_ZERO_BYPASS_EN
            if (shift_amt == '0) begin
                r_data_out <= data_in;
            end
`endif
        end else if (r_state == c_SHIFT) begin
            r_work <= w_work_next;
            r_cnt  <= r_cnt - 1'b1;
            // Stage 0 is the final one: publish the result on the same edge.
            if (r_cnt == '0) begin
                r_data_out <= w_work_next;
            end
        end
    end

    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_serial.sv
`default_nettype none
// Testbench for shift_right_serial: queued expectations from a >>/>>> model,
// checked by an independent output monitor.
module tb_shift_right_serial;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  data_in;
    logic [SHAMT_W-1:0] shift_amt;
    logic               arith;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  data_out;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                lat;
        int                acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic              prev_ov;
    logic [DATA_W-1:0] prev_d;

    shift_right_serial #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d,
                                                input int a, input logic ar);
        logic signed [DATA_W-1:0] s;
        s = d;
        return ar ? DATA_W'(s >>> a) : (d >> a);
    endfunction

    // Edges from accept to the first cycle with out_valid high.
    function automatic int exp_lat(input int a);
`ifdef SHIFT_RIGHT_ZERO_BYPASS_EN
        if (a == 0) return 0;
`endif
        return SHAMT_W;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [DATA_W-1:0] d, input int a,
                         input logic ar, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        data_in   = d;
        shift_amt = SHAMT_W'(a);
        arith     = ar;
        in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            q.push_back('{d: model(d, a, ar), lat: exp_lat(a), acc: cyc});
            in_valid = 1'b0;
        end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (q.size() > 0) begin
                checks++;
                if (in_ready) begin
                    errors++;
                    $display("FAIL busy_in_ready: got 1 expected 0");
                end
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got out_valid=1 expected 0");
                end else begin
                    if (!prev_ov) begin
                        checks++;
                        if (cyc - q[0].acc != q[0].lat) begin
                            errors++;
                            $display("FAIL latency: got %0d expected %0d",
                                     cyc - q[0].acc, q[0].lat);
                        end
                    end else begin
                        check("hold_data", data_out, prev_d);
                    end
                    if (out_ready) begin
                        check("result", data_out, q[0].d);
                        void'(q.pop_front());
                    end
                end
            end
            prev_ov = out_valid;
            prev_d  = data_out;
        end
    end

    initial begin
        int acc;
        int t_raise;
        int n;
        logic [DATA_W-1:0] rd;
        int ra;
        logic rar;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        shift_amt = '0;
        arith     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", DATA_W'(in_ready), 1);
        check("rst_out_valid", DATA_W'(out_valid), 0);
        check("rst_data_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed shifts
        issue(32'h8000_0000, 31, 1'b0, acc);
        drain();
        issue(32'h8000_0000, 4, 1'b1, acc);
        issue(32'h7FFF_FFF0, 4, 1'b1, acc);
        issue(32'hF000_0000, 4, 1'b0, acc);
        issue(32'h8000_0000, 31, 1'b1, acc);
        issue(32'h1234_5678, 0, 1'b0, acc);
        issue(32'h8765_4321, 0, 1'b1, acc);
        drain();

        // Backpressure with a held request
        out_ready = 1'b0;
        issue(32'hC000_0000, 8, 1'b1, acc);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", DATA_W'(out_valid), 1);
        data_in   = 32'h0000_0F00;
        shift_amt = 5'd8;
        arith     = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_held", DATA_W'(out_valid), 1);
        end
        out_ready = 1'b1;
        t_raise   = cyc;
        issue(32'h0000_0F00, 8, 1'b0, acc);
        check("bp_reaccept_edge", DATA_W'(acc - t_raise), 2);
        drain();

        // Asynchronous reset mid-operation
        issue(32'hDEAD_BEEF, 3, 1'b1, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", DATA_W'(out_valid), 0);
        check("midrst_in_ready", DATA_W'(in_ready), 1);
        check("midrst_data_out", data_out, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_0002, 1, 1'b0, acc);
        drain();

        // Random back-to-back traffic
        for (int i = 0; i < 100; i++) begin
            rd  = $urandom;
            ra  = (i % 10 == 0) ? ((i % 20 == 0) ? 0 : 31) : int'($urandom_range(0, 31));
            rar = 1'(($urandom >> 3) & 1);
            issue(rd, ra, rar, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
